// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and default constants for the LFSR sequencer/arbiter.
package lfsr_ctrl_pkg;

    localparam int unsigned     LFSR_W   = 8;
    localparam logic [LFSR_W-1:0] TAPS_DEF = 8'hB8;
    localparam logic [LFSR_W-1:0] SEED_DEF = 8'h01;

    typedef enum logic [1:0] {
        ST_SEED    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_STEP    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to the requester not granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    // prio_q is the index that wins a tie; it starts at requester 0.
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o  = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
        prio_d = prio_q;
        if (adv_i && (req_i != 2'b00)) prio_d = ~gnt_o[1];
    end

    always_ff @(posedge clk) begin
        if (!reset_i) prio_q <= 1'b0;
        else          prio_q <= prio_d;
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Seeds an external shift-left LFSR serially, steps it per request and hands bytes out round-robin.
// Optional all-zero lockup detection/recovery is enabled by defining LFSR_LOCKUP_DET_EN.
module lfsr_seq_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS         = TAPS_DEF,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = SEED_DEF,
    parameter int unsigned       STEPS        = 8
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              seed_load_i,
    input  logic [1:0]        req_i,
    input  logic [LFSR_W-1:0] lfsr_q_i,
    output logic              lfsr_en_o,
    output logic              lfsr_fb_o,
    output logic [1:0]        valid_o,
    output logic [LFSR_W-1:0] data_o,
    output logic              busy_o,
    output logic              lockup_o
);

    localparam logic [7:0] STEP_LAST = 8'(STEPS - 1);

    state_e            state_q;
    logic [LFSR_W-1:0] seed_q;
    logic [7:0]        cnt_q;
    logic [1:0]        grant_q;
    logic [1:0]        valid_q;
    logic              lockup_q;
    logic [1:0]        gnt;
    logic              take_req;
    logic              zero_hit;

    assign take_req = (state_q == ST_IDLE) && !seed_load_i && (req_i != 2'b00);

`ifdef LFSR_LOCKUP_DET_EN
    assign zero_hit = (state_q == ST_STEP) && (lfsr_q_i == '0);
    assign lockup_o = lockup_q;
`else
    assign zero_hit = 1'b0;
    assign lockup_o = 1'b0;
`endif

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_i (reset_i),
        .req_i   (req_i),
        .adv_i   (take_req),
        .gnt_o   (gnt)
    );

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            state_q  <= ST_SEED;
            seed_q   <= SEED_DEFAULT;
            cnt_q    <= '0;
            grant_q  <= '0;
            valid_q  <= '0;
            lockup_q <= 1'b0;
        end else begin
            valid_q <= '0;
            case (state_q)
                ST_SEED: begin
                    if (cnt_q == 8'd7) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (seed_load_i) begin
                        seed_q   <= (seed_i == '0) ? SEED_DEFAULT : seed_i;
                        lockup_q <= 1'b0;
                        state_q  <= ST_SEED;
                    end else if (req_i != 2'b00) begin
                        grant_q <= gnt;
                        state_q <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    // Lockup recovery keeps grant_q; the level request re-arbitrates after reseed.
                    if (zero_hit) begin
                        lockup_q <= 1'b1;
                        seed_q   <= SEED_DEFAULT;
                        cnt_q    <= '0;
                        state_q  <= ST_SEED;
                    end else if (cnt_q == STEP_LAST) begin
                        cnt_q   <= '0;
                        valid_q <= grant_q;
                        state_q <= ST_DELIVER;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DELIVER: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // The LFSR is held quiet while reset is asserted, whatever the state register holds.
    always_comb begin
        lfsr_en_o = 1'b0;
        lfsr_fb_o = 1'b0;
        if (reset_i) begin
            case (state_q)
                ST_SEED: begin
                    lfsr_en_o = 1'b1;
                    lfsr_fb_o = seed_q[3'd7 - cnt_q[2:0]];
                end
                ST_STEP: begin
                    lfsr_en_o = 1'b1;
                    lfsr_fb_o = ^(lfsr_q_i & TAPS);
                end
                default: ;
            endcase
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign valid_o = valid_q;
    assign data_o  = lfsr_q_i;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench: two controllers (STEPS=1 and STEPS=8) each driving a behavioural LFSR, checked against an event-level model.
module tb_lfsr_seq_ctrl;

    logic       clk;
    logic       reset_i;
    logic [7:0] seed_i;
    logic       seed_load_i;
    logic [1:0] req_i;
    logic       force_zero;
    logic       chk_on;

    logic       en     [2];
    logic       fb     [2];
    logic       busy   [2];
    logic       lockup [2];
    logic [1:0] valid  [2];
    logic [7:0] data   [2];
    logic [7:0] lq     [2];
    logic [7:0] lq_i   [2];

    int n_chk  = 0;
    int n_fail = 0;

    lfsr_seq_ctrl #(.STEPS(1)) u_dut0 (
        .clk(clk), .reset_i(reset_i), .seed_i(seed_i), .seed_load_i(seed_load_i),
        .req_i(req_i), .lfsr_q_i(lq_i[0]), .lfsr_en_o(en[0]), .lfsr_fb_o(fb[0]),
        .valid_o(valid[0]), .data_o(data[0]), .busy_o(busy[0]), .lockup_o(lockup[0])
    );

    lfsr_seq_ctrl #(.STEPS(8)) u_dut1 (
        .clk(clk), .reset_i(reset_i), .seed_i(seed_i), .seed_load_i(seed_load_i),
        .req_i(req_i), .lfsr_q_i(lq_i[1]), .lfsr_en_o(en[1]), .lfsr_fb_o(fb[1]),
        .valid_o(valid[1]), .data_o(data[1]), .busy_o(busy[1]), .lockup_o(lockup[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shift-left LFSRs, reset together with the system.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_i)   lq[k] <= 8'h00;
            else if (en[k]) lq[k] <= {lq[k][6:0], fb[k]};
        end
    end
    assign lq_i[0] = force_zero ? 8'h00 : lq[0];
    assign lq_i[1] = force_zero ? 8'h00 : lq[1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v, input int unsigned cnt);
        logic [7:0] r;
        r = v;
        for (int unsigned i = 0; i < cnt; i++) r = {r[6:0], ^(r & 8'hB8)};
        return r;
    endfunction

    // Event-level model: edge index at which each block is idle again, and pending delivery.
    int          n = 0;
    int          steps      [2] = '{1, 8};
    int          idle_at    [2] = '{1000000, 1000000};
    int          deliver_at [2] = '{-1, -1};
    int          who        [2] = '{0, 0};
    int          prio       [2] = '{0, 0};
    logic [7:0]  m_lfsr     [2] = '{8'h01, 8'h01};
    logic [7:0]  dlv_data   [2] = '{8'h00, 8'h00};

    always @(posedge clk) begin
        n = n + 1;
        for (int k = 0; k < 2; k++) begin
            if (!reset_i) begin
                idle_at[k]    = n + 8;
                deliver_at[k] = -1;
                prio[k]       = 0;
                m_lfsr[k]     = 8'h01;
            end else if (n - 1 >= idle_at[k]) begin
                if (seed_load_i) begin
                    m_lfsr[k]  = (seed_i == 8'h00) ? 8'h01 : seed_i;
                    idle_at[k] = n + 8;
                end else if (req_i != 2'b00) begin
                    who[k]        = (req_i == 2'b11) ? prio[k] : ((req_i == 2'b10) ? 1 : 0);
                    prio[k]       = 1 - who[k];
                    m_lfsr[k]     = lfsr_adv(m_lfsr[k], steps[k]);
                    dlv_data[k]   = m_lfsr[k];
                    deliver_at[k] = n + steps[k];
                    idle_at[k]    = n + steps[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on && n > 0) begin
            for (int k = 0; k < 2; k++) begin
                logic       e_busy;
                logic       e_dlv;
                logic [1:0] e_valid;
                e_busy  = (n < idle_at[k]);
                e_dlv   = (n == deliver_at[k]);
                e_valid = e_dlv ? (2'b01 << who[k]) : 2'b00;
                check($sformatf("busy%0d", k), 32'(busy[k]), 32'(e_busy));
                check($sformatf("valid%0d", k), 32'(valid[k]), 32'(e_valid));
                check($sformatf("en%0d", k), 32'(en[k]), 32'(reset_i && e_busy && !e_dlv));
                check($sformatf("lockup%0d", k), 32'(lockup[k]), 32'(0));
                if (e_dlv) check($sformatf("data%0d", k), 32'(data[k]), 32'(dlv_data[k]));
                if (n == idle_at[k]) check($sformatf("lfsr_q%0d", k), 32'(lq_i[k]), 32'(m_lfsr[k]));
            end
        end
    end

    task automatic wait_both_idle();
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy[0] && !busy[1]) break;
        end
        if (i == 60) check("idle_timeout", 32'(i), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_d [4];
        logic [1:0] exp_v [4];
        logic [1:0] seen  [$];
        int         bc;
        int         r;
        exp_d = '{8'h02, 8'h04, 8'h08, 8'h11};
        exp_v = '{2'b01, 2'b10, 2'b01, 2'b10};

        reset_i = 1'b0; seed_i = 8'h00; seed_load_i = 1'b0; req_i = 2'b00;
        force_zero = 1'b0; chk_on = 1'b1;

        // Reset then 8-cycle seeding to 8'h01.
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b1;
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy[0]) break;
            bc++;
        end
        check("reset_busy_cycles", 32'(bc), 32'(8));
        check("reset_seed_value", 32'(lq_i[0]), 32'h01);

        // STEPS=1, alternating single requests.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            req_i = (i % 2 == 1) ? 2'b10 : 2'b01;
            @(posedge clk); #1 req_i = 2'b00;
            @(negedge clk);
            check("single_early_valid", 32'(valid[0]), 32'(0));
            @(negedge clk);
            check("single_valid", 32'(valid[0]), 32'(exp_v[i]));
            check("single_data", 32'(data[0]), 32'(exp_d[i]));
            @(posedge clk); #1;
        end

        // Both requesting: grants alternate, never both.
        req_i = 2'b11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid[0] != 2'b00) seen.push_back(valid[0]);
        end
        check("tie_grant_count", 32'(seen.size()), 32'(4));
        for (int i = 0; i < 4 && i < seen.size(); i++)
            check("tie_grant", 32'(seen[i]), 32'((i % 2 == 1) ? 2'b10 : 2'b01));
        @(posedge clk); #1 req_i = 2'b00;
        wait_both_idle();

        // Reseed with zero seed beats a simultaneous request.
        seed_i = 8'h00; seed_load_i = 1'b1; req_i = 2'b01;
        @(posedge clk); #1 seed_load_i = 1'b0;
        bc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy[0]) bc++;
        end
        check("reseed_busy_cycles", 32'(bc), 32'(8));
        @(negedge clk);
        check("reseed_idle", 32'(busy[0]), 32'(0));
        check("reseed_value", 32'(lq_i[0]), 32'h01);
        @(posedge clk); #1 req_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("reseed_then_valid", 32'(valid[0]), 32'(2'b01));
        check("reseed_then_data", 32'(data[0]), 32'h02);
        wait_both_idle();

        // Reset during the fourth STEP cycle of the STEPS=8 instance.
        req_i = 2'b01;
        @(posedge clk); #1 req_i = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        check("midstep_busy", 32'(busy[1]), 32'(1));
        check("midstep_valid", 32'(valid[1]), 32'(0));
        check("midstep_en", 32'(en[1]), 32'(0));
        check("midstep_lockup", 32'(lockup[1]), 32'(0));
        @(posedge clk); #1 reset_i = 1'b1;
        wait_both_idle();
        req_i = 2'b11;
        @(posedge clk); #1 req_i = 2'b00;
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid[1] != 2'b00) break;
            bc++;
        end
        check("midstep_rr_first", 32'(valid[1]), 32'(2'b01));
        check("midstep_latency", 32'(bc), 32'(8));
        wait_both_idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 900; i++) begin
            r = $urandom_range(0, 99);
            reset_i     = (r != 0);
            seed_load_i = (r >= 1 && r <= 4);
            seed_i      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) req_i = 2'($urandom);
            @(posedge clk); #1;
        end
        reset_i = 1'b1; seed_load_i = 1'b0; req_i = 2'b00;
        wait_both_idle();

`ifdef LFSR_LOCKUP_DET_EN
        // Forced all-zero LFSR during STEP: lockup, reseed, then the held request is served.
        chk_on = 1'b0;
        req_i = 2'b01;
        @(posedge clk); #1 force_zero = 1'b1;
        @(posedge clk); #1 force_zero = 1'b0;
        @(negedge clk);
        check("lockup_set", 32'(lockup[0]), 32'(1));
        check("lockup_busy", 32'(busy[0]), 32'(1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid[0] != 2'b00) break;
        end
        check("lockup_valid", 32'(valid[0]), 32'(2'b01));
        check("lockup_data", 32'(data[0]), 32'h02);
        req_i = 2'b00;
        wait_both_idle();
        seed_i = 8'h5A; seed_load_i = 1'b1;
        @(posedge clk); #1 seed_load_i = 1'b0;
        @(negedge clk);
        check("lockup_cleared", 32'(lockup[0]), 32'(0));
        wait_both_idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
